// File: rtl/zx_scandoubler.sv
// Doubles the ULA 15 kHz pixel stream to a 31 kHz stream. Each input line goes into a
// ping-pong line buffer and is replayed twice. Line length and HSync width are measured from the input.
module zx_scandoubler #(
  parameter int unsigned HW       = 9,
  parameter int unsigned DEF_LINE = 448,
  parameter int unsigned DEF_HS   = 32
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix_in,
  input  logic       ce_pix_out,
  input  logic       scanlines,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       hb_in,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hb_out,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [2:0] b_out,
  output logic       line_ovf
);
  typedef enum logic [1:0] {FIRST, SECOND, HOLD} state_t;

  logic [9:0]    mem [0:(2**(HW+1))-1];
  logic [HW-1:0] in_hcnt, out_hcnt, cnt_nx, hs_len;
  logic [HW:0]   line_len;
  logic [1:0]    lines;
  logic          hs_d, wr_bank, sat, vs_line, scan_en;
  logic          rise, fall, restart, at_end, blank, dim;
  logic [9:0]    rd;
  state_t        state, state_nx;

  assign rise    = hs_in & ~hs_d;
  assign fall    = ~hs_in & hs_d;
  assign restart = ce_pix_in & rise;

  always_ff @(posedge clk_sys)
    if (ce_pix_in && !sat) mem[{wr_bank, in_hcnt}] <= {hb_in, r_in, g_in, b_in};

  // The rising-edge pixel closes the old line, so the sync started one count before in_hcnt = 0.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_d     <= 1'b0;
      in_hcnt  <= '0;
      wr_bank  <= 1'b0;
      sat      <= 1'b0;
      line_ovf <= 1'b0;
      vs_line  <= 1'b0;
      lines    <= '0;
      line_len <= (HW+1)'(DEF_LINE);
      hs_len   <= HW'(DEF_HS);
    end else if (ce_pix_in) begin
      hs_d <= hs_in;
      if (sat) line_ovf <= 1'b1;
      if (rise) begin
        if (lines != 2'd0) line_len <= {1'b0, in_hcnt} + (HW+1)'(1);
        if (lines != 2'd2) lines <= lines + 2'd1;
        in_hcnt <= '0;
        wr_bank <= ~wr_bank;
        vs_line <= vs_in;
        sat     <= 1'b0;
      end else begin
        if (in_hcnt == '1) sat <= 1'b1;
        else               in_hcnt <= in_hcnt + HW'(1);
        if (fall) hs_len <= in_hcnt + HW'(1);
      end
    end
  end

  assign at_end = ({1'b0, out_hcnt} == line_len - (HW+1)'(1));

  always_comb begin
    state_nx = state;
    cnt_nx   = out_hcnt;
    if (restart) begin
      state_nx = FIRST;
      cnt_nx   = '0;
    end else begin
      case (state)
        FIRST:
          if (at_end) begin
            state_nx = SECOND;
            cnt_nx   = '0;
          end else cnt_nx = out_hcnt + HW'(1);
        SECOND:
          if (at_end) state_nx = HOLD;
          else        cnt_nx = out_hcnt + HW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= FIRST;
      out_hcnt <= '0;
      scan_en  <= 1'b0;
    end else if (ce_pix_out) begin
      state    <= state_nx;
      out_hcnt <= cnt_nx;
      if (restart) scan_en <= scanlines;
    end
  end

  // Blank is forced until two input syncs have been seen, because the read bank is not yet a full line.
  assign rd    = mem[{~wr_bank, out_hcnt}];
  assign blank = rd[9] | (state == HOLD) | (lines != 2'd2);
  assign dim   = scan_en & (state != FIRST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      hb_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else if (ce_pix_out) begin
      hs_out <= (out_hcnt < hs_len);
      vs_out <= vs_line;
      hb_out <= blank;
      r_out  <= blank ? '0 : (dim ? rd[8:6] >> 1 : rd[8:6]);
      g_out  <= blank ? '0 : (dim ? rd[5:3] >> 1 : rd[5:3]);
      b_out  <= blank ? '0 : (dim ? rd[2:0] >> 1 : rd[2:0]);
    end
  end
endmodule
